seq_detector_param: RTL and testbench
=====================================

Name: seq_detector_param

Overview:
Parametrised serial pattern detector for the board-level FSM labs. It samples one input bit per qualified clock and compares a sliding history window against a run-time-loadable pattern of programmable length. It supports overlapping and non-overlapping detection and keeps a saturating match counter. It replaces fixed hard-coded sequence FSMs and drives LEDR and HEX status in the top level.

Parameters:
MAX_LEN, 8, maximum pattern length in bits (≥2)
CNT_W, 8, match counter width
RST_LEN, 4, pattern length after reset (1..MAX_LEN)
RST_PAT, 8'b0000_1101, pattern after reset; bit [len-1] is the first bit expected, bit [0] the last
LEN_W (localparam), $clog2(MAX_LEN+1), width of length fields

Ports:
clock  in  1  system clock; all state updates on the rising edge
resetn  in  1  synchronous, active-low reset
w  in  1  serial data bit
w_valid  in  1  qualifies w; sampled only when high
load  in  1  one-cycle request to load a new pattern
pat_in  in  MAX_LEN  new pattern, right-justified
len_in  in  LEN_W  new pattern length
overlap  in  1  1 = overlapping detection, 0 = non-overlapping
clr_count  in  1  synchronous clear of match_count
match  out  1  detection indication (registered)
fill  out  LEN_W  valid history bits currently held, 0..len (progress)
match_count  out  CNT_W  number of detections, saturating
cur_len  out  LEN_W  active pattern length

Behaviour:
- Reset (resetn=0 at an edge): pat_reg=RST_PAT, len_reg=RST_LEN, hist=0, fill=0, match=0, match_count=0. Reset overrides all other inputs.
- Pattern compare (decided fact): hist_next = {hist[MAX_LEN-2:0], w}; fill_next = min(fill+1, len_reg).
  - hit = (fill_next == len_reg) && (hist_next[len_reg-1:0] == pat_reg[len_reg-1:0]).
  - Bits above len_reg-1 are ignored.
- On an edge with w_valid=1 and load=0:
  - hist <= hist_next; match <= hit.
  - On hit with overlap=1: fill <= len_reg.
  - On hit with overlap=0: fill <= 0 and hist is retained, but because fill restarts, len_reg fresh bits are needed before the next hit.
  - No hit: fill <= fill_next.
- On an edge with w_valid=0: hist and fill hold; match <= 0 (pulse mode).
- Latency: match is high during the cycle after the edge that samples the completing bit. It is exactly 1 cycle wide per hit, and back-to-back hits give consecutive high cycles.
- Load:
  - load=1 with 1 ≤ len_in ≤ MAX_LEN: pat_reg <= pat_in, len_reg <= len_in, hist <= 0, fill <= 0, match <= 0. match_count is unaffected.
  - load=1 with len_in=0 or len_in>MAX_LEN: the request is ignored entirely and all state holds.
  - load and w_valid in the same cycle: load wins and the bit is dropped.
- Counter:
  - On hit, match_count increments, saturating at 2^CNT_W-1.
  - clr_count=1 sets it to 0. If clr_count and a hit occur in the same cycle, the result is 0 (clear wins).
- overlap may change at any time; it is applied at the next hit.
- cur_len = len_reg.

Optional Feature:
Macro SEQDET_HOLD_EN.
- Defined: match is level/Moore-style. It sets on hit and stays high through idle cycles (w_valid=0) until the next sampled bit, at which point it takes that bit's hit value. load and reset clear it.
- Not defined: match is a one-cycle pulse as described in Behaviour.

Test Plan:
1. Reset, then w=1,1,0,1 with w_valid every cycle → match=1 only in the cycle after the 4th bit; match_count=1; fill=0,1,2,3,4 across the sequence.
2. Load pat=3'b101, len=3, overlap=1; stream 1,0,1,0,1 → match after bits 3 and 5; count=2. Repeat with overlap=0 → match after bit 3 only; count=1; fill=2 at the end.
3. Default pattern; stream 1,1,0,1 with w_valid=0 gaps of 3 cycles between bits → exactly one match pulse, one cycle after the last valid edge; fill holds during gaps. With SEQDET_HOLD_EN, match stays high until the next valid bit.
4. Mid-stream load after bits 1,1,0 (len_in=2, pat=2'b01), with w_valid=1 in the load cycle → that bit is dropped and fill=0; then 0,1 → match; count=1.
5. load with len_in=0 or MAX_LEN+1 → pat, len, fill and hist unchanged; detection of the previous pattern continues.
6. CNT_W=2 build: 5 hits → count saturates at 3. clr_count asserted in the same cycle as a hit → count=0.

Source files
------------

// File: rtl/seq_detector_param.sv
// seq_detector_param: serial pattern detector with a run-time loadable
// pattern and length. It supports overlapping and non-overlapping detection
// and keeps a saturating match counter.
// Optional build macro SEQDET_HOLD_EN:
//   defined     -> match is level style and holds through idle cycles
//   not defined -> match is a one-cycle pulse per hit
module seq_detector_param #(
  parameter int                   MAX_LEN = 8,
  parameter int                   CNT_W   = 8,
  parameter int                   RST_LEN = 4,
  parameter logic [MAX_LEN-1:0]   RST_PAT = 8'b0000_1101,
  localparam int                  LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic               w,
  input  logic               w_valid,
  input  logic               load,
  input  logic [MAX_LEN-1:0] pat_in,
  input  logic [LEN_W-1:0]   len_in,
  input  logic               overlap,
  input  logic               clr_count,
  output logic               match,
  output logic [LEN_W-1:0]   fill,
  output logic [CNT_W-1:0]   match_count,
  output logic [LEN_W-1:0]   cur_len
);

  localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] RST_LEN_L = LEN_W'(RST_LEN);

  logic [MAX_LEN-1:0] pat_q, pat_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [MAX_LEN-1:0] hist_q, hist_d;
  logic [LEN_W-1:0]   fill_q, fill_d;
  logic               match_q, match_d;
  logic [CNT_W-1:0]   count_q, count_d;

  logic [MAX_LEN-1:0] hist_nx;
  logic [MAX_LEN-1:0] len_mask;
  logic [LEN_W-1:0]   fill_nx;
  logic               load_ok;
  logic               sample;
  logic               hit;

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Window compare: shifted history against the active pattern, masked to len.
  always_comb begin
    hist_nx = {hist_q[MAX_LEN-2:0], w};
    fill_nx = (fill_q < len_q) ? fill_q + LEN_W'(1) : len_q;
    for (int i = 0; i < MAX_LEN; i++) begin
      len_mask[i] = (i < int'(len_q));
    end
    // An out-of-range load request is treated as if load were low.
    load_ok = load && (len_in != '0) && (len_in <= MAX_LEN_L);
    sample  = w_valid && !load_ok;
    hit     = sample && (fill_nx == len_q) &&
              ((hist_nx & len_mask) == (pat_q & len_mask));
  end

  // Next-state selection: a valid load wins over a sampled bit.
  always_comb begin
    pat_d  = pat_q;
    len_d  = len_q;
    hist_d = hist_q;
    fill_d = fill_q;
`ifdef SEQDET_HOLD_EN
    match_d = match_q;
`else
    match_d = 1'b0;
`endif
    if (load_ok) begin
      pat_d   = pat_in;
      len_d   = len_in;
      hist_d  = '0;
      fill_d  = '0;
      match_d = 1'b0;
    end else if (sample) begin
      hist_d  = hist_nx;
      match_d = hit;
      if (hit) begin
        // Non-overlapping mode needs len fresh bits before the next hit.
        fill_d = overlap ? len_q : '0;
      end else begin
        fill_d = fill_nx;
      end
    end
    if (clr_count) begin
      count_d = '0;
    end else if (hit) begin
      count_d = sat_inc(count_q);
    end else begin
      count_d = count_q;
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      pat_q   <= RST_PAT;
      len_q   <= RST_LEN_L;
      hist_q  <= '0;
      fill_q  <= '0;
      match_q <= 1'b0;
      count_q <= '0;
    end else begin
      pat_q   <= pat_d;
      len_q   <= len_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      match_q <= match_d;
      count_q <= count_d;
    end
  end

  assign match       = match_q;
  assign fill        = fill_q;
  assign match_count = count_q;
  assign cur_len     = len_q;

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed bench for seq_detector_param. A second instance built with a
// 2-bit counter shares the stimulus to exercise counter saturation.
module tb_seq_detector_param;

`ifdef SEQDET_HOLD_EN
  localparam logic HOLD = 1'b1;
`else
  localparam logic HOLD = 1'b0;
`endif

  logic       clock;
  logic       resetn;
  logic       w;
  logic       w_valid;
  logic       load;
  logic [7:0] pat_in;
  logic [3:0] len_in;
  logic       overlap;
  logic       clr_count;

  logic       match;
  logic [3:0] fill;
  logic [7:0] match_count;
  logic [3:0] cur_len;

  logic       match2;
  logic [3:0] fill2;
  logic [1:0] count2;
  logic [3:0] cur_len2;

  int n_vec = 0;
  int n_err = 0;

  seq_detector_param dut (
    .clock(clock), .resetn(resetn), .w(w), .w_valid(w_valid), .load(load),
    .pat_in(pat_in), .len_in(len_in), .overlap(overlap), .clr_count(clr_count),
    .match(match), .fill(fill), .match_count(match_count), .cur_len(cur_len)
  );

  seq_detector_param #(.CNT_W(2)) dut2 (
    .clock(clock), .resetn(resetn), .w(w), .w_valid(w_valid), .load(load),
    .pat_in(pat_in), .len_in(len_in), .overlap(overlap), .clr_count(clr_count),
    .match(match2), .fill(fill2), .match_count(count2), .cur_len(cur_len2)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    w_valid   = 1'b0;
    load      = 1'b0;
    clr_count = 1'b0;
  endtask

  task automatic bitin(input logic b);
    w       = b;
    w_valid = 1'b1;
    tick();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_load(input logic [7:0] p, input logic [3:0] l, input logic c);
    pat_in    = p;
    len_in    = l;
    load      = 1'b1;
    clr_count = c;
    tick();
  endtask

  initial begin
    resetn = 1'b0; w = 1'b0; w_valid = 1'b0; load = 1'b0;
    pat_in = '0; len_in = '0; overlap = 1'b1; clr_count = 1'b0;
    idle(2);
    chk("rst_match", match, 0);
    chk("rst_fill", fill, 0);
    chk("rst_count", match_count, 0);
    chk("rst_len", cur_len, 4);
    resetn = 1'b1;

    // Default pattern 1101
    bitin(1); chk("t1_fill1", fill, 1); chk("t1_m1", match, 0);
    bitin(1); chk("t1_fill2", fill, 2);
    bitin(0); chk("t1_fill3", fill, 3); chk("t1_m3", match, 0);
    bitin(1); chk("t1_match", match, 1); chk("t1_fill4", fill, 4);
    chk("t1_count", match_count, 1);
    idle(1); chk("t1_after", match, HOLD); chk("t1_fillhold", fill, 4);

    // Pattern 101, overlapping
    do_load(8'b101, 3, 1);
    chk("t2_len", cur_len, 3); chk("t2_fill0", fill, 0);
    chk("t2_m0", match, 0); chk("t2_clr", match_count, 0);
    bitin(1); bitin(0);
    bitin(1); chk("t2o_m3", match, 1); chk("t2o_fill3", fill, 3);
    bitin(0); chk("t2o_m4", match, 0); chk("t2o_fill4", fill, 3);
    bitin(1); chk("t2o_m5", match, 1); chk("t2o_cnt", match_count, 2);

    // Pattern 101, non-overlapping
    overlap = 1'b0;
    do_load(8'b101, 3, 1);
    bitin(1); bitin(0);
    bitin(1); chk("t2n_m3", match, 1); chk("t2n_fill3", fill, 0);
    bitin(0); chk("t2n_m4", match, 0); chk("t2n_fill4", fill, 1);
    bitin(1); chk("t2n_m5", match, 0); chk("t2n_fill5", fill, 2);
    chk("t2n_cnt", match_count, 1);

    // Gapped stream on the default pattern
    overlap = 1'b1;
    do_load(8'b1101, 4, 1);
    bitin(1); idle(3); chk("t3_gap_fill1", fill, 1);
    bitin(1); idle(3);
    bitin(0); idle(3); chk("t3_gap_fill3", fill, 3); chk("t3_gap_m", match, 0);
    bitin(1); chk("t3_match", match, 1); chk("t3_cnt", match_count, 1);
    idle(1); chk("t3_idle1", match, HOLD);
    idle(1); chk("t3_idle2", match, HOLD); chk("t3_fill", fill, 4);

    // Mid-stream load with a simultaneous valid bit
    do_load(8'b1101, 4, 1);
    bitin(1); bitin(1); bitin(0); chk("t4_fill3", fill, 3);
    w = 1'b1; w_valid = 1'b1; pat_in = 8'b01; len_in = 4'd2; load = 1'b1;
    tick();
    chk("t4_ld_fill", fill, 0); chk("t4_ld_len", cur_len, 2); chk("t4_ld_m", match, 0);
    bitin(0); chk("t4_fill1", fill, 1); chk("t4_m1", match, 0);
    bitin(1); chk("t4_match", match, 1); chk("t4_cnt", match_count, 1);

    // Out-of-range loads are ignored
    do_load(8'hFF, 4'd0, 0);
    chk("t5_len0_len", cur_len, 2); chk("t5_len0_fill", fill, 2);
    chk("t5_len0_cnt", match_count, 1);
    do_load(8'hFF, 4'd9, 0);
    chk("t5_len9_len", cur_len, 2); chk("t5_len9_fill", fill, 2);
    bitin(0); chk("t5_fill", fill, 2); chk("t5_m0", match, 0);
    bitin(1); chk("t5_match", match, 1); chk("t5_cnt", match_count, 2);

    // Saturation and clear-versus-hit priority
    clr_count = 1'b1; tick();
    chk("t6_clr", match_count, 0); chk("t6_clr2", count2, 0);
    for (int i = 0; i < 3; i++) begin
      bitin(0); bitin(1);
    end
    chk("t6_cnt3", match_count, 3); chk("t6_sat3", count2, 3);
    bitin(0); bitin(1);
    bitin(0); bitin(1);
    chk("t6_cnt5", match_count, 5); chk("t6_sat5", count2, 3);
    chk("t6_m2", match2, 1); chk("t6_fill2", fill2, 2); chk("t6_len2", cur_len2, 2);
    bitin(0);
    w = 1'b1; w_valid = 1'b1; clr_count = 1'b1;
    tick();
    chk("t6_hitclr_m", match, 1);
    chk("t6_hitclr_cnt", match_count, 0); chk("t6_hitclr_cnt2", count2, 0);

    // Reset restores the default pattern
    resetn = 1'b0; w = 1'b1; w_valid = 1'b1; load = 1'b1; tick();
    chk("t7_len", cur_len, 4); chk("t7_fill", fill, 0);
    chk("t7_cnt", match_count, 0); chk("t7_m", match, 0);
    resetn = 1'b1;
    bitin(1); bitin(1); bitin(0);
    bitin(1); chk("t7_match", match, 1); chk("t7_cnt1", match_count, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
